uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART byte transmitter between `NREQ` requesters using round-robin arbitration with packet locking. Each requester offers bytes on a valid/ready handshake. The arbiter loads the selected byte, pulses the transmitter's start input, and follows its busy flag until the byte is on the wire. It sits between the command/status sources and the UART transmit datapath, and owns all sequencing of the transmitter.

## Interface
Parameters:
- `NREQ`, 4 — number of requesters, 2..8
- `DATA_W`, 8 — byte width
- `TIMEOUT`, 16 — cycles allowed for `tx_busy` to rise after `tx_start`

Ports:
- `clk`  in  1  — single system clock, rising edge
- `rst_n`  in  1  — asynchronous, active-low reset
- `req_valid`  in  NREQ  — requester i has a byte on its data slice
- `req_data`  in  NREQ*DATA_W  — slice i is `[i*DATA_W +: DATA_W]`
- `req_last`  in  NREQ  — byte is the last of its packet; releases the lock
- `req_ready`  out  NREQ  — one-hot; byte i accepted when `req_valid[i] & req_ready[i]`
- `tx_start`  out  1  — one-cycle start pulse to the transmitter
- `tx_data`  out  DATA_W  — byte to transmit; held stable from `tx_start` until `tx_busy` falls
- `tx_busy`  in  1  — transmitter is shifting
- `grant_id`  out  clog2(NREQ)  — currently granted requester
- `active`  out  1  — a packet is in progress (state ≠ IDLE)
- `err`  out  1  — sticky; `tx_busy` failed to rise within `TIMEOUT`

## Operation
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - When any `req_valid` is high, pick the first valid index scanning from `(last_grant+1) mod NREQ` upward with wrap.
  - Register that index into `grant_id`, then go to LOAD.
  - With no valid request, stay in IDLE.
- **LOAD**
  - `req_ready[grant_id]`=1; all other `req_ready` bits are 0.
  - On `req_valid[grant_id]`: capture the data slice into `tx_data` and `req_last` into `last_q`, then go to START.
  - Without valid: stay in LOAD. The packet lock holds, and other requesters are not served mid-packet.
- **START**
  - `tx_start`=1 for exactly this cycle, then go to WAIT_BUSY.
  - Clear the timeout counter.
- **WAIT_BUSY**
  - On `tx_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches `TIMEOUT-1`, set `err` and treat the byte as done (same exit as WAIT_DONE).
- **WAIT_DONE**
  - On `tx_busy`=0:
    - If `last_q`=0, go to LOAD with the same grant.
    - If `last_q`=1, set `last_grant`=`grant_id` and go to IDLE.
- **Fairness:** a requester cannot win twice in a row while any other requester is valid in IDLE.
- **Single-byte packets:** `req_last`=1 on the first byte gives byte-granular round-robin.
- **`err`:** cleared only by reset.
- **Registered outputs:** `tx_data`, `grant_id`, `err` and `tx_start` are registered. `req_ready` and `active` are decoded from state.

## Timing
- **Reset values:** state IDLE, `last_grant`=NREQ-1 (so requester 0 has first priority), `grant_id`=0, `tx_data`=0, `tx_start`=0, `req_ready`=0, `active`=0, `err`=0, counter 0, `last_q`=0.
- **Latency:**
  - `req_valid` high at cycle 0 in IDLE → `req_ready` at cycle 1 → `tx_start` at cycle 2.
  - `tx_data` is valid from cycle 2.
- **Back-to-back within a packet:** `tx_busy` falls at cycle n → `req_ready` at n+1 → `tx_start` at n+2.
- **Packet end to next grant:** `tx_busy` falls at n → IDLE at n+1 → next `req_ready` at n+2.
- **Simultaneous events:**
  - A new `req_valid` in the same cycle `tx_busy` falls is seen only after return to IDLE.
  - `tx_busy` already high during START is ignored; it is sampled first in WAIT_BUSY.
- **Requester contract:** `req_valid` may drop in LOAD without penalty. Requesters must not change data while `req_valid & ~req_ready`.
- **Reset mid-operation:** asserting `rst_n` low forces all outputs to reset values asynchronously, including `tx_start` in the same cycle. No partial byte is re-issued after release.
- **Timeout width:** counter is clog2(TIMEOUT) bits, saturating (no wrap). With `TIMEOUT`=16 and `tx_busy` stuck low, `err` rises 16 cycles after `tx_start`.

## Test plan
- **Basic byte:** reset, then `req_valid[2]`=1, data 0xA5, `last`=1 → `req_ready`=0100 at cycle 1, `tx_start` pulse at cycle 2 with `tx_data`=0xA5, `grant_id`=2. Bench raises `tx_busy` for 10 cycles → back to IDLE, `active`=0.
- **Round-robin:** all four requesters valid with single-byte packets (0x10..0x13), repeated → transmit order 0,1,2,3,0,1.
- **Packet lock:** requester 1 sends 3 bytes (0x31, 0x32, 0x33 with `last` on 0x33) while requester 0 is valid → all three of requester 1's bytes go out contiguously, then requester 2 or 0 per the pointer (0 if 2 and 3 are idle). Requester 1 dropping `req_valid` for 5 cycles mid-packet stalls the arbiter in LOAD without granting requester 0.
- **Timeout:** `tx_busy` held 0 after `tx_start` → `err`=1 exactly 16 cycles later; the arbiter continues to the next packet and `err` stays 1.
- **Mid-byte reset:** pull `rst_n` low during WAIT_DONE → all outputs 0 immediately; after release, requester 0 wins first when all are valid.
- **Edge timing:** `tx_busy` falling in the same cycle as a new `req_valid[3]` → `req_ready[3]` appears 2 cycles later, not 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter with packet locking that shares one UART byte transmitter among NREQ requesters.
// Ports:
//   clk, rst_n      system clock (rising edge), asynchronous active-low reset
//   req_valid[i]    requester i offers the byte on req_data[i*DATA_W +: DATA_W]
//   req_last[i]     that byte ends its packet and releases the lock
//   req_ready[i]    one-hot accept strobe, high only for the granted requester while loading
//   tx_start        one-cycle start pulse to the transmitter
//   tx_data         byte to transmit, stable from tx_start until tx_busy falls
//   tx_busy         transmitter is shifting
//   grant_id        currently granted requester
//   active          a packet is in progress
//   err             sticky flag: tx_busy did not rise within TIMEOUT cycles of tx_start
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      active,
    output logic                      err
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] WAIT_BUSY = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;

    logic [2:0]    state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] pick;
    logic [CW-1:0] cnt;
    logic          last_q;
    logic          timeout_hit;
    logic          byte_done;

    // Scan downward so the nearest valid index after last_grant is assigned last and wins.
    always_comb begin
        pick = last_grant;
        for (int k = NREQ; k > 0; k--)
            if (req_valid[(int'(last_grant) + k) % NREQ]) pick = GW'((int'(last_grant) + k) % NREQ);
    end

    // The counter advances to TIMEOUT-1 on the cycle that flags the timeout, so err
    // becomes visible TIMEOUT cycles after tx_start.
    assign timeout_hit = (state == WAIT_BUSY) && !tx_busy && (cnt == CW'(TIMEOUT - 2));
    assign byte_done   = ((state == WAIT_DONE) && !tx_busy) || timeout_hit;
    assign req_ready   = (state == LOAD) ? NREQ'(1) << grant_id : '0;
    assign active      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GW'(NREQ - 1);
            grant_id   <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            err        <= 1'b0;
            cnt        <= '0;
            last_q     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: if (|req_valid) begin
                    grant_id <= pick;
                    state    <= LOAD;
                end
                LOAD: if (req_valid[grant_id]) begin
                    tx_data  <= req_data[int'(grant_id)*DATA_W +: DATA_W];
                    last_q   <= req_last[grant_id];
                    tx_start <= 1'b1;
                    state    <= START;
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) state <= WAIT_DONE;
                    else cnt <= (&cnt) ? cnt : cnt + 1'b1;
                    if (timeout_hit) err <= 1'b1;
                end
                WAIT_DONE: ;
                default: state <= IDLE;
            endcase
            if (byte_done) begin
                state <= last_q ? IDLE : LOAD;
                if (last_q) last_grant <= grant_id;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter with a transmitter model and a transmit-order scoreboard.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TO   = 16;

    typedef struct { int id; logic [7:0] data; logic last; int gap; } byte_t;
    typedef struct { int id; logic [7:0] data; } exp_t;
    typedef struct { logic [3:0] mask; logic [7:0] base; int n; logic [3:0][1:0] order; } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_start;
    logic [DW-1:0]        tx_data;
    logic                 tx_busy;
    logic [1:0]           grant_id;
    logic                 active;
    logic                 err;

    byte_t pend[$];
    exp_t  expq[$];
    vec_t  vecs[8];
    int    n_vec = 0;
    int    n_err = 0;
    int    busy_len = 10;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
        .active(active), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find(input int i);
        for (int k = 0; k < pend.size(); k++)
            if (pend[k].id == i) return k;
        return -1;
    endfunction

    task automatic wait_idle(input string name);
        int c = 0;
        logic idle = 1'b0;
        while (!idle && c < 400) begin
            @(negedge clk);
            c++;
            idle = pend.size() == 0 && expq.size() == 0 && !active && !tx_busy;
        end
        n_vec++;
        if (!idle) begin
            n_err++;
            $display("FAIL %s: still busy after %0d cycles, %0d bytes expected", name, c, expq.size());
        end
    endtask

    task automatic wait_start(input string name);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!tx_start && c < 100);
        check(name, tx_start, 1'b1);
    endtask

    // Requesters: each presents its oldest pending byte; a gap holds valid low for
    // that many cycles of being granted, modelling a requester that stalls mid-packet.
    initial begin : driver
        logic [3:0] acc;
        int hold[NREQ];
        int f;
        for (int i = 0; i < NREQ; i++) hold[i] = 0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    f = find(i);
                    if (f >= 0) pend.delete(f);
                    f = find(i);
                    hold[i] = 0;
                    if (f >= 0) hold[i] = pend[f].gap;
                end
                f = find(i);
                req_valid[i]          = f >= 0 && hold[i] == 0;
                req_data[i*DW +: DW]  = 8'h00;
                req_last[i]           = 1'b0;
                if (f >= 0) begin
                    req_data[i*DW +: DW] = pend[f].data;
                    req_last[i]          = pend[f].last;
                end
                if (hold[i] > 0 && req_ready[i]) hold[i]--;
            end
        end
    end

    // Transmitter model and scoreboard: every tx_start pops the next expected byte.
    initial begin : monitor
        exp_t e;
        logic [7:0] held = 8'h00;
        int rem = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rem     = 0;
                tx_busy = 1'b0;
            end else begin
                if (req_ready != 0) check("ready_onehot", req_ready, 32'(1) << grant_id);
                if (tx_start) begin
                    if (expq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_start: grant %0d data 0x%0h, expected no start", grant_id, tx_data);
                    end else begin
                        e = expq.pop_front();
                        check("tx_grant", grant_id, e.id);
                        check("tx_data", tx_data, e.data);
                    end
                    held = tx_data;
                    if (busy_len > 0) begin
                        tx_busy = 1'b1;
                        rem     = busy_len;
                    end
                end else if (rem > 0) begin
                    rem--;
                    if (rem == 0) begin
                        tx_busy = 1'b0;
                        check("tx_data_hold", tx_data, held);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: still running at %0t, limit 400000", $time);
        $fatal(1);
    end

    initial begin : main
        int c;
        vecs = '{
            '{4'b1111, 8'h10, 4, {2'd3, 2'd2, 2'd1, 2'd0}},
            '{4'b0011, 8'h20, 2, {2'd0, 2'd0, 2'd1, 2'd0}},
            '{4'b1101, 8'h40, 3, {2'd0, 2'd0, 2'd3, 2'd2}},
            '{4'b0001, 8'h50, 1, {2'd0, 2'd0, 2'd0, 2'd0}},
            '{4'b1001, 8'h60, 2, {2'd0, 2'd0, 2'd0, 2'd3}},
            '{4'b0110, 8'h70, 2, {2'd0, 2'd0, 2'd2, 2'd1}},
            '{4'b1011, 8'h80, 3, {2'd0, 2'd1, 2'd0, 2'd3}},
            '{4'b0001, 8'h90, 1, {2'd0, 2'd0, 2'd0, 2'd0}}
        };
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_start", tx_start, 0);
        check("rst_data", tx_data, 0);
        check("rst_grant", grant_id, 0);
        check("rst_active", active, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_active", active, 0);

        // Basic byte: valid at cycle 0, ready at 1, start at 2.
        pend.push_back('{2, 8'hA5, 1'b1, 0});
        expq.push_back('{2, 8'hA5});
        @(negedge clk);
        check("basic_c0_ready", req_ready, 0);
        check("basic_c0_active", active, 0);
        @(negedge clk);
        check("basic_c1_ready", req_ready, 4'b0100);
        check("basic_c1_grant", grant_id, 2);
        check("basic_c1_start", tx_start, 0);
        @(negedge clk);
        check("basic_c2_start", tx_start, 1);
        check("basic_c2_data", tx_data, 8'hA5);
        check("basic_c2_ready", req_ready, 0);
        wait_idle("basic_done");
        check("basic_idle", active, 0);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Round-robin table of single-byte packets.
        foreach (vecs[v]) begin
            for (int i = 0; i < NREQ; i++)
                if (vecs[v].mask[i]) pend.push_back('{i, 8'(vecs[v].base + i), 1'b1, 0});
            for (int k = 0; k < vecs[v].n; k++)
                expq.push_back('{int'(vecs[v].order[k]), 8'(vecs[v].base + vecs[v].order[k])});
            wait_idle("rr_vector");
        end

        // Packet lock with a 5-cycle stall before the second byte.
        pend.push_back('{1, 8'h31, 1'b0, 0});
        pend.push_back('{1, 8'h32, 1'b0, 5});
        pend.push_back('{1, 8'h33, 1'b1, 0});
        pend.push_back('{0, 8'h01, 1'b1, 0});
        expq.push_back('{1, 8'h31});
        expq.push_back('{1, 8'h32});
        expq.push_back('{1, 8'h33});
        expq.push_back('{0, 8'h01});
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(req_ready[1] && !req_valid[1]) && c < 100);
        check("lock_stall_seen", req_ready, 4'b0010);
        repeat (4) @(negedge clk);
        check("lock_stall_ready", req_ready, 4'b0010);
        check("lock_stall_grant", grant_id, 1);
        wait_idle("lock_done");

        // Timeout: tx_busy never rises for the first byte.
        busy_len = 0;
        pend.push_back('{2, 8'hC2, 1'b1, 0});
        pend.push_back('{3, 8'hC3, 1'b1, 0});
        expq.push_back('{2, 8'hC2});
        expq.push_back('{3, 8'hC3});
        wait_start("to_start");
        repeat (15) @(negedge clk);
        check("to_err_early", err, 0);
        @(negedge clk);
        check("to_err_set", err, 1);
        busy_len = 10;
        wait_idle("to_done");
        check("to_err_sticky", err, 1);

        // Mid-byte reset in WAIT_DONE, then requester 0 first.
        pend.push_back('{1, 8'hE1, 1'b1, 0});
        expq.push_back('{1, 8'hE1});
        wait_idle("mr_pre");
        for (int i = 0; i < NREQ; i++) pend.push_back('{i, 8'(8'hD0 + i), 1'b1, 0});
        expq.push_back('{2, 8'hD2});
        expq.push_back('{0, 8'hD0});
        expq.push_back('{1, 8'hD1});
        expq.push_back('{3, 8'hD3});
        wait_start("mr_start");
        repeat (3) @(negedge clk);
        check("mr_active_before", active, 1);
        rst_n = 1'b0;
        #1;
        check("mr_active", active, 0);
        check("mr_start_out", tx_start, 0);
        check("mr_ready", req_ready, 0);
        check("mr_grant", grant_id, 0);
        check("mr_data", tx_data, 0);
        check("mr_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle("mr_done");

        // tx_busy falls in the same cycle req_valid[3] rises.
        pend.push_back('{0, 8'hF0, 1'b1, 0});
        expq.push_back('{0, 8'hF0});
        wait_start("edge_start");
        repeat (9) @(negedge clk);
        pend.push_back('{3, 8'hF3, 1'b1, 0});
        expq.push_back('{3, 8'hF3});
        @(negedge clk);
        check("edge_n_ready", req_ready, 0);
        check("edge_n_active", active, 1);
        @(negedge clk);
        check("edge_n1_ready", req_ready, 0);
        check("edge_n1_active", active, 0);
        @(negedge clk);
        check("edge_n2_ready", req_ready, 4'b1000);
        check("edge_n2_grant", grant_id, 3);
        wait_idle("edge_done");

        check("sb_drain", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
